adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter DATAW, default 8, meaning operand and sum width in bits (signed two's complement).
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing the adder (>=2).
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester operand-valid.
REQ-006 The block SHALL have port req_ready_o  output  NUM_REQ  per-requester accept strobe.
REQ-007 The block SHALL have port req_a_i  input  NUM_REQ x DATAW  signed operand A per requester.
REQ-008 The block SHALL have port req_b_i  input  NUM_REQ x DATAW  signed operand B per requester.
REQ-009 The block SHALL have port rsp_valid_o  output  1  result valid.
REQ-010 The block SHALL have port rsp_ready_i  input  1  downstream accepts result.
REQ-011 The block SHALL have port rsp_id_o  output  $clog2(NUM_REQ)  index of requester that produced the result.
REQ-012 The block SHALL have port rsp_sum_o  output  DATAW  signed saturated sum.

Function
REQ-013 A transfer SHALL occur on a requester when req_valid_i[i] && req_ready_o[i] at a rising edge; on the response side when rsp_valid_o && rsp_ready_i.
REQ-014 The output stage SHALL be a two-state FSM: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
REQ-015 Accept condition SHALL be acc = (state==EMPTY) || rsp_ready_i; grants are issued only when acc is true.
REQ-016 When acc and any req_valid_i is set, exactly one req_ready_o bit SHALL be 1: the first valid index scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ; otherwise req_ready_o SHALL be all zero.
REQ-017 req_ready_o MAY depend combinationally on req_valid_i and rsp_ready_i; requesters SHALL NOT make req_valid_i depend on req_ready_o.
REQ-018 On a grant to index g, ptr SHALL become (g+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0; with no grant ptr SHALL hold.
REQ-019 On a grant, rsp_sum_o SHALL load sat(req_a_i[g]+req_b_i[g]), rsp_id_o SHALL load g, and state SHALL go to FULL at the same edge (latency: result visible 1 cycle after acceptance).
REQ-020 sat() SHALL compute the exact DATAW+1-bit sum and clamp to [-2^(DATAW-1), 2^(DATAW-1)-1].
REQ-021 FULL with rsp_ready_i=1 and no grant SHALL go to EMPTY; FULL with rsp_ready_i=1 and a grant SHALL stay FULL with the new result (back-to-back, full throughput).
REQ-022 FULL with rsp_ready_i=0 SHALL hold rsp_sum_o, rsp_id_o, rsp_valid_o stable and issue no grants.
REQ-023 EMPTY with no valid requester SHALL stay EMPTY; rsp_sum_o/rsp_id_o are don't-care while rsp_valid_o=0 but SHALL only change on a grant.
REQ-024 Operands SHALL be sampled only at the granting edge; operand changes at other times SHALL have no effect.

Reset
REQ-025 rst_i high SHALL asynchronously force state=EMPTY, ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_sum_o=0, and req_ready_o all zero while asserted.
REQ-026 Reset mid-operation SHALL discard any held result; no requester transfer SHALL be recorded on an edge where rst_i is high.
REQ-027 After rst_i deasserts, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-028 A shared package adder_pkg SHALL hold the default DATAW, default NUM_REQ and the output-stage state enum (EMPTY, FULL).
REQ-029 The combinational saturating sum SHALL be a single instance of the existing adder sub-module (ports dataa_i, datab_i, sum_o, parameter DATAW) fed by the granted requester's operands.
REQ-030 Arbitration, ptr and output register SHALL live in adder_arbiter; no other sub-modules.

Verification
REQ-031 Single request: req 2 valid a=1,b=2, rsp_ready_i=1 -> req_ready_o=4'b0100 that cycle; next cycle rsp_valid_o=1, rsp_id_o=2, rsp_sum_o=3.
REQ-032 Saturation: a=124,b=4 -> 127; a=-127,b=-2 -> -128; a=8,b=-8 -> 0.
REQ-033 Round-robin: all 4 valid continuously, rsp_ready_i=1 -> rsp_id_o sequence 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-034 Backpressure: FULL, rsp_ready_i=0 for 3 cycles with req 1 valid -> req_ready_o=0, outputs stable; on rsp_ready_i=1 the same edge drains and grants req 1.
REQ-035 Wrap: ptr=3, only req 0 and 3 valid -> grant 3 then 0, ptr returns to 0 then 1.
REQ-036 Reset mid-stall: FULL with rsp_sum_o=127, assert rst_i between edges -> rsp_valid_o=0 immediately; after release, requests 1 and 0 valid -> grant 0 first.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and output-stage state encoding for the adder arbiter.
package adder_pkg;
  localparam int DEF_DATAW   = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/adder.sv
// Combinational signed adder that clamps the exact sum into the DATAW range.
module adder
  import adder_pkg::*;
#(
  parameter int DATAW = DEF_DATAW
) (
  input  logic [DATAW-1:0] dataa_i,
  input  logic [DATAW-1:0] datab_i,
  output logic [DATAW-1:0] sum_o
);

  // Overflow shows up as disagreement between the two top bits of the exact sum.
  function automatic logic [DATAW-1:0] sat(input logic signed [DATAW:0] s);
    if (s[DATAW] != s[DATAW-1]) begin
      sat = s[DATAW] ? {1'b1, {(DATAW-1){1'b0}}} : {1'b0, {(DATAW-1){1'b1}}};
    end else begin
      sat = s[DATAW-1:0];
    end
  endfunction

  logic signed [DATAW:0] full_s;

  always_comb begin
    full_s = $signed({dataa_i[DATAW-1], dataa_i}) + $signed({datab_i[DATAW-1], datab_i});
    sum_o  = sat(full_s);
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one saturating adder among NUM_REQ requesters,
// with a single-entry registered result stage that supports full throughput.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int DATAW   = DEF_DATAW,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATAW-1:0]   req_a_i,
  input  logic [NUM_REQ*DATAW-1:0]   req_b_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [DATAW-1:0]           rsp_sum_o
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef logic [IDW-1:0] idx_t;
  typedef logic [IDW:0]   wide_t;

  localparam wide_t NUM_REQ_W = wide_t'(NUM_REQ);
  localparam idx_t  LAST_IDX  = idx_t'(NUM_REQ - 1);

  state_e           state_q, state_d;
  idx_t             ptr_q, ptr_d;
  idx_t             id_q, id_d;
  logic [DATAW-1:0] sum_q, sum_d;

  logic             acc;
  logic             found;
  logic             grant;
  idx_t             grant_idx;
  wide_t            cand;
  logic [DATAW-1:0] a_sel, b_sel, sum_sel;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and take the first valid requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + wide_t'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req_valid_i[cand[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    acc         = (state_q == EMPTY) || rsp_ready_i;
    grant       = acc && found && !rst_i;
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == idx_t'(i)) begin
        a_sel = req_a_i[i*DATAW +: DATAW];
        b_sel = req_b_i[i*DATAW +: DATAW];
      end
    end
  end

  adder #(
    .DATAW (DATAW)
  ) u_adder (
    .dataa_i (a_sel),
    .datab_i (b_sel),
    .sum_o   (sum_sel)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    if (grant) begin
      state_d = FULL;
      ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      id_d    = grant_idx;
      sum_d   = sum_sel;
    end else if (state_q == FULL && rsp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_id_o    = id_q;
  assign rsp_sum_o   = sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the round-robin / saturating-sum behaviour.
module tb_adder_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_sum;

  int total = 0;
  int bad   = 0;

  int op_a[NR];
  int op_b[NR];

  // reference model state
  bit m_full;
  int m_ptr;
  int m_id;
  int m_sum;

  adder_arbiter #(.DATAW(DW), .NUM_REQ(NR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_ref(input int a, input int b);
    int s;
    s = a + b;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic int model_grant();
    if (rst) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int g;
    logic [NR-1:0] r;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = op_a[i][DW-1:0];
      req_b[i*DW +: DW] = op_b[i][DW-1:0];
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_id   = 0;
    m_sum  = 0;
  endtask

  // Advance one clock edge and step the model with the inputs present at it.
  task automatic tick();
    int g;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_full = 1'b1;
        m_id   = g;
        m_sum  = sat_ref(op_a[g], op_b[g]);
        m_ptr  = (g + 1) % NR;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin op_a[i] = i; op_b[i] = i; end
    drive_ops();
    model_reset();
    tick();
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_sum !== 8'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", rsp_sum); end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    op_a[2] = 1; op_b[2] = 2;
    drive_ops();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    total++; if ($signed(rsp_sum) !== 8'sd3) begin bad++; $display("FAIL single_sum got=%0d exp=3", $signed(rsp_sum)); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_saturation();
    int ta[3] = '{124, -127, 8};
    int tb[3] = '{4, -2, -8};
    int te[3] = '{127, -128, 0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_a[0] = ta[i]; op_b[0] = tb[i];
      drive_ops();
      req_valid = 4'b0001;
      tick();
      total++;
      if (int'($signed(rsp_sum)) !== te[i] || rsp_valid !== 1'b1) begin
        bad++; $display("FAIL sat_%0d got=%0d/%b exp=%0d/1", i, $signed(rsp_sum), rsp_valid, te[i]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NR; i++) begin
        op_a[i] = $urandom_range(255) - 128;
        op_b[i] = $urandom_range(255) - 128;
      end
      drive_ops();
      #1;
      total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rr_ready_%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) !== seq[c] || int'($signed(rsp_sum)) !== m_sum) begin
        bad++; $display("FAIL rr_rsp_%0d got=%b/%0d/%0d exp=1/%0d/%0d", c, rsp_valid, rsp_id, $signed(rsp_sum), seq[c], m_sum);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int held;
    pulse_reset();
    rsp_ready = 1'b1;
    op_a[0] = 50; op_b[0] = 25;
    drive_ops();
    req_valid = 4'b0001;
    tick();
    held = 75;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      op_a[1] = $urandom_range(255) - 128;
      op_b[1] = $urandom_range(255) - 128;
      drive_ops();
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=0000", c, req_ready); end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || int'($signed(rsp_sum)) !== held) begin
        bad++; $display("FAIL bp_hold_%0d got=%b/%0d/%0d exp=1/0/%0d", c, rsp_valid, rsp_id, $signed(rsp_sum), held);
      end
    end
    op_a[1] = -100; op_b[1] = -60;
    drive_ops();
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || int'($signed(rsp_sum)) !== -128) begin
      bad++; $display("FAIL bp_release_rsp got=%b/%0d/%0d exp=1/1/-128", rsp_valid, rsp_id, $signed(rsp_sum));
    end
    tick();
  endtask

  task automatic test_wrap();
    // ptr is 2 here; a grant to 2 moves it to 3
    rsp_ready = 1'b1;
    op_a[0] = 3; op_b[0] = 4; op_a[2] = 1; op_b[2] = 1; op_a[3] = -5; op_b[3] = 2;
    drive_ops();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", req_ready); end
    tick();
    total++; if (rsp_id !== 2'd3 || int'($signed(rsp_sum)) !== -3) begin bad++; $display("FAIL wrap_rsp3 got=%0d/%0d exp=3/-3", rsp_id, $signed(rsp_sum)); end
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b exp=0001", req_ready); end
    tick();
    total++; if (rsp_id !== 2'd0 || int'($signed(rsp_sum)) !== 7) begin bad++; $display("FAIL wrap_rsp0 got=%0d/%0d exp=0/7", rsp_id, $signed(rsp_sum)); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1 got=%b exp=0010", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    rsp_ready = 1'b1;
    op_a[0] = 100; op_b[0] = 100;
    drive_ops();
    req_valid = 4'b0001;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    tick();
    total++; if (rsp_valid !== 1'b1 || $signed(rsp_sum) !== 8'sd127) begin bad++; $display("FAIL rst_stall_pre got=%b/%0d exp=1/127", rsp_valid, $signed(rsp_sum)); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0) begin bad++; $display("FAIL rst_stall_async got=%b/%0d exp=0/0", rsp_valid, rsp_sum); end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_stall_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    op_a[1] = 9; op_b[1] = 9; op_a[0] = -1; op_b[0] = -1;
    drive_ops();
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_stall_first got=%b exp=0001", req_ready); end
    tick();
    total++; if (rsp_id !== 2'd0 || int'($signed(rsp_sum)) !== -2) begin bad++; $display("FAIL rst_stall_rsp got=%0d/%0d exp=0/-2", rsp_id, $signed(rsp_sum)); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom_range(15));
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NR; i++) begin
        op_a[i] = $urandom_range(255) - 128;
        op_b[i] = $urandom_range(255) - 128;
      end
      drive_ops();
      #1;
      total++;
      if (req_ready !== exp_ready()) begin
        bad++; $display("FAIL rand_ready_%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      tick();
      total++;
      if (rsp_valid !== m_full || int'(rsp_id) !== m_id || int'($signed(rsp_sum)) !== m_sum) begin
        bad++; $display("FAIL rand_rsp_%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c, rsp_valid, rsp_id, $signed(rsp_sum), m_full, m_id, m_sum);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    model_reset();
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
